pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 3, number of tracked post-decode stages (index 0=E ... DEPTH-1=W), legal 3..8.
REQ-002 SHALL have parameter NREG, default 16, architectural register count; RW=$clog2(NREG); index NREG-1 is the PC.
REQ-003 SHALL have parameter LD_STAGE, default DEPTH-1, first stage index whose load data is forwardable, legal 1..DEPTH-1.
REQ-004 SHALL have parameter FWD_EN, default 1; 0 means no forwarding, stall-only mode.
REQ-005 SHALL have parameter CNTW, default 32, perf-counter width.
REQ-006 SHALL have ports: clk in 1, clock; reset in 1, synchronous active-high reset.
REQ-007 SHALL have ports: dec_valid in 1; dec_ra1, dec_ra2, dec_rd in RW; dec_regwrite, dec_memtoreg, dec_pcsrc in 1; all describe the instruction in Decode.
REQ-008 SHALL have port branch_taken_e in 1, branch resolved taken in E.
REQ-009 SHALL have outputs stall_f, stall_d, flush_d, flush_e, each 1 bit.
REQ-010 SHALL have outputs fwd_a, fwd_b, each FW=$clog2(DEPTH) bits, operand select for E (0=register file, k=stage k result).
REQ-011 SHALL have outputs stall_cnt, flush_cnt, each CNTW bits.

Function
REQ-012 SHALL hold a DEPTH-entry tag chain; entry fields {valid, rd, regwrite, memtoreg, pcsrc}; entry 0 additionally holds ra1, ra2.
REQ-013 Each clk edge SHALL shift entry k to k+1 (entry DEPTH-1 retires); stages beyond E never stall.
REQ-014 Entry 0 SHALL load decode fields with valid=dec_valid, unless flush_e=1, in which case entry 0 becomes invalid (bubble).
REQ-015 Entry k SHALL "match" operand r when valid, regwrite, rd==r, and r!=NREG-1.
REQ-016 FWD_EN=1: fwd_a SHALL equal the smallest k in 1..DEPTH-1 whose entry matches entry0.ra1 and (memtoreg=0 or k>=LD_STAGE); else 0; fwd_b likewise for ra2. Youngest match wins.
REQ-017 FWD_EN=1: ld_stall SHALL be 1 when dec_valid and some entry j matches dec_ra1 or dec_ra2 with memtoreg=1 and j+1<LD_STAGE.
REQ-018 FWD_EN=0: fwd_a=fwd_b=0 always; ld_stall SHALL be 1 when dec_valid and any entry j<=DEPTH-2 matches dec_ra1 or dec_ra2 (register file write-before-read covers stage DEPTH-1).
REQ-019 pc_pend SHALL be 1 when (dec_valid and dec_pcsrc) or any valid entry k<=DEPTH-2 has pcsrc.
REQ-020 Outputs SHALL be combinational: stall_d=ld_stall; stall_f=ld_stall|pc_pend; flush_e=ld_stall|branch_taken_e; flush_d=pc_pend|branch_taken_e|(valid pcsrc in entry DEPTH-1).
REQ-021 ld_stall and branch_taken_e same cycle: both flushes apply; stall_d=1 and stall_f=1; branch redirect has priority in the datapath.
REQ-022 stall_cnt SHALL increment by 1 each cycle stall_f=1; flush_cnt by 1 each cycle flush_d|flush_e=1; both saturate at all-ones, never wrap.

Reset
REQ-023 On reset=1 at a clk edge, all entries SHALL become invalid and both counters 0, regardless of in-flight instructions.
REQ-024 With all entries invalid, dec_valid=0 and branch_taken_e=0, every output SHALL be 0.
REQ-025 Reset asserted mid-stall SHALL drop the stall the next cycle if decode inputs are idle; no hazard state survives reset.

Verification (DEPTH=3, NREG=16, LD_STAGE=2, FWD_EN=1 unless stated)
REQ-026 ADD r1 then ADD using r1 in ra1 back-to-back -> fwd_a=1 when consumer is in E; no stall.
REQ-027 ADD r1 writer at stage 1 and ADD r1 writer at stage 2, consumer reads r1 -> fwd_a=1 (youngest wins).
REQ-028 LDR r2 then ADD using r2 in ra2 -> one cycle stall_f=stall_d=flush_e=1, then fwd_b=2; stall_cnt=1, flush_cnt=1.
REQ-029 branch_taken_e=1 with dec_valid=1 -> flush_d=flush_e=1 same cycle; next cycle entry 0 invalid.
REQ-030 LDR pc (dec_pcsrc=1) -> stall_f=1 and flush_d=1 for 3 consecutive cycles (D, E, M), then flush_d=1 alone 1 cycle (W); FWD_EN=0 dependent ADD pair -> stall 2 cycles; CNTW=2 counter stops at 3.
REQ-031 reset pulse while load-use stall active -> next cycle all outputs 0, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for an in-order pipeline: tag chain of post-decode stages
// driving forwarding selects, load-use / PC-write stalls, flushes and counters.
module pipe_hazard_ctrl #(
  parameter int DEPTH    = 3,
  parameter int NREG     = 16,
  parameter int LD_STAGE = DEPTH - 1,
  parameter int FWD_EN   = 1,
  parameter int CNTW     = 32,
  localparam int RW = $clog2(NREG),
  localparam int FW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  input  logic [RW-1:0]   dec_ra1,
  input  logic [RW-1:0]   dec_ra2,
  input  logic [RW-1:0]   dec_rd,
  input  logic            dec_regwrite,
  input  logic            dec_memtoreg,
  input  logic            dec_pcsrc,
  input  logic            branch_taken_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e,
  output logic [FW-1:0]   fwd_a,
  output logic [FW-1:0]   fwd_b,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  localparam logic [RW-1:0] PC_IDX = RW'(NREG - 1);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         regwrite_q, regwrite_d;
  logic [DEPTH-1:0]         memtoreg_q, memtoreg_d;
  logic [DEPTH-1:0]         pcsrc_q, pcsrc_d;
  logic [DEPTH-1:0][RW-1:0] rd_q, rd_d;
  logic [RW-1:0]            ra1_q, ra1_d;
  logic [RW-1:0]            ra2_q, ra2_d;
  logic [CNTW-1:0]          stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0]          flush_cnt_q, flush_cnt_d;

  logic [DEPTH-1:0] e_hit_a, e_hit_b;
  logic [DEPTH-1:0] d_hit_a, d_hit_b;
  logic             ld_stall;
  logic             pc_pend;
  logic             lds_any;
  logic             live;

  // Operand match per entry, for the E-stage operands and the D-stage ones.
  always_comb begin
    e_hit_a = '0;
    e_hit_b = '0;
    d_hit_a = '0;
    d_hit_b = '0;
    live    = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      live       = valid_q[k] & regwrite_q[k];
      e_hit_a[k] = live && (rd_q[k] == ra1_q) && (ra1_q != PC_IDX);
      e_hit_b[k] = live && (rd_q[k] == ra2_q) && (ra2_q != PC_IDX);
      d_hit_a[k] = live && (rd_q[k] == dec_ra1) && (dec_ra1 != PC_IDX);
      d_hit_b[k] = live && (rd_q[k] == dec_ra2) && (dec_ra2 != PC_IDX);
    end
  end

  // Scan oldest to youngest so the youngest forwardable producer wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (FWD_EN != 0) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (e_hit_a[k] && (!memtoreg_q[k] || k >= LD_STAGE)) begin
          fwd_a = FW'(k);
        end
        if (e_hit_b[k] && (!memtoreg_q[k] || k >= LD_STAGE)) begin
          fwd_b = FW'(k);
        end
      end
    end
  end

  // Without forwarding only the last stage is covered by the register file.
  always_comb begin
    lds_any = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (FWD_EN != 0) begin
        if ((d_hit_a[j] || d_hit_b[j]) && memtoreg_q[j] && (j + 1 < LD_STAGE)) begin
          lds_any = 1'b1;
        end
      end else begin
        if ((d_hit_a[j] || d_hit_b[j]) && (j <= DEPTH - 2)) begin
          lds_any = 1'b1;
        end
      end
    end
    ld_stall = dec_valid & lds_any;
  end

  always_comb begin
    pc_pend = (dec_valid & dec_pcsrc)
            | (|(valid_q[DEPTH-2:0] & pcsrc_q[DEPTH-2:0]));
    stall_d = ld_stall;
    stall_f = ld_stall | pc_pend;
    flush_e = ld_stall | branch_taken_e;
    flush_d = pc_pend | branch_taken_e
            | (valid_q[DEPTH-1] & pcsrc_q[DEPTH-1]);
  end

  always_comb begin
    valid_d    = {valid_q[DEPTH-2:0], dec_valid & ~flush_e};
    regwrite_d = {regwrite_q[DEPTH-2:0], dec_regwrite};
    memtoreg_d = {memtoreg_q[DEPTH-2:0], dec_memtoreg};
    pcsrc_d    = {pcsrc_q[DEPTH-2:0], dec_pcsrc};
    rd_d       = {rd_q[DEPTH-2:0], dec_rd};
    ra1_d      = dec_ra1;
    ra2_d      = dec_ra2;
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
    if ((flush_d || flush_e) && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      regwrite_q  <= '0;
      memtoreg_q  <= '0;
      pcsrc_q     <= '0;
      rd_q        <= '0;
      ra1_q       <= '0;
      ra2_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      pcsrc_q     <= pcsrc_d;
      rd_q        <= rd_d;
      ra1_q       <= ra1_d;
      ra2_q       <= ra2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: default instance plus a
// stall-only instance with a 2-bit counter.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] rd;
    logic       rw;
    logic       m2r;
    logic       pc;
    logic       br;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic [7:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dec_valid = 1'b0;
  logic [3:0] dec_ra1 = '0, dec_ra2 = '0, dec_rd = '0;
  logic dec_regwrite = 1'b0, dec_memtoreg = 1'b0, dec_pcsrc = 1'b0;
  logic branch_taken_e = 1'b0;

  logic stall_f, stall_d, flush_d, flush_e;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;
  logic nf_stall_f, nf_stall_d, nf_flush_d, nf_flush_e;
  logic [1:0] nf_fwd_a, nf_fwd_b;
  logic [1:0] nf_stall_cnt, nf_flush_cnt;
  logic [7:0] obs, obs_nf;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_rd(dec_rd),
    .dec_regwrite(dec_regwrite), .dec_memtoreg(dec_memtoreg),
    .dec_pcsrc(dec_pcsrc), .branch_taken_e(branch_taken_e),
    .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.FWD_EN(0), .CNTW(2)) dut_nf (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_rd(dec_rd),
    .dec_regwrite(dec_regwrite), .dec_memtoreg(dec_memtoreg),
    .dec_pcsrc(dec_pcsrc), .branch_taken_e(branch_taken_e),
    .stall_f(nf_stall_f), .stall_d(nf_stall_d),
    .flush_d(nf_flush_d), .flush_e(nf_flush_e),
    .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b),
    .stall_cnt(nf_stall_cnt), .flush_cnt(nf_flush_cnt)
  );

  assign obs    = {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b};
  assign obs_nf = {nf_stall_f, nf_stall_d, nf_flush_d, nf_flush_e,
                   nf_fwd_a, nf_fwd_b};

  function automatic stim_t mk(input logic v, input logic [3:0] ra1,
                               input logic [3:0] ra2, input logic [3:0] rd,
                               input logic rw, input logic m2r,
                               input logic pc, input logic br);
    return '{v: v, ra1: ra1, ra2: ra2, rd: rd,
             rw: rw, m2r: m2r, pc: pc, br: br};
  endfunction

  task automatic apply(input stim_t s);
    dec_valid      = s.v;
    dec_ra1        = s.ra1;
    dec_ra2        = s.ra2;
    dec_rd         = s.rd;
    dec_regwrite   = s.rw;
    dec_memtoreg   = s.m2r;
    dec_pcsrc      = s.pc;
    branch_taken_e = s.br;
  endtask

  task automatic do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL reset_out got=%b want=%b", obs, 8'h00);
    end
    total++;
    if (obs_nf !== 8'h00) begin
      bad++; $display("FAIL reset_out_nf got=%b want=%b", obs_nf, 8'h00);
    end
    total++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fwd_alu();
    vec_t v[$];
    logic [7:0] e;
    do_reset();
    v.push_back({mk(1, 3, 4, 1, 1, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(1, 1, 5, 6, 1, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b0000_01_00});
    v.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b0000_00_00});
    foreach (v[i]) begin
      apply(v[i].s); exp_q.push_back(v[i].e);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++; $display("FAIL fwd_alu cyc%0d got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest();
    vec_t v[$];
    logic [7:0] e;
    do_reset();
    v.push_back({mk(1, 9, 10, 1, 1, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(1, 7, 8, 1, 1, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(1, 1, 1, 12, 1, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b0000_01_01});
    foreach (v[i]) begin
      apply(v[i].s); exp_q.push_back(v[i].e);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++; $display("FAIL youngest cyc%0d got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    vec_t v[$];
    logic [7:0] e;
    do_reset();
    v.push_back({mk(1, 3, 4, 2, 1, 1, 0, 0), 8'b0000_00_00});
    v.push_back({mk(1, 5, 2, 6, 1, 0, 0, 0), 8'b1101_00_00});
    v.push_back({mk(1, 5, 2, 6, 1, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b0000_00_10});
    v.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b0000_00_00});
    foreach (v[i]) begin
      apply(v[i].s); exp_q.push_back(v[i].e);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++; $display("FAIL load_use cyc%0d got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
    total++;
    if (stall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin
      bad++; $display("FAIL load_use_cnt got=%0d/%0d want=1/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_branch();
    vec_t v[$];
    logic [7:0] e;
    do_reset();
    v.push_back({mk(1, 0, 0, 3, 1, 1, 0, 1), 8'b0011_00_00});
    v.push_back({mk(1, 3, 0, 8, 1, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b0000_00_00});
    foreach (v[i]) begin
      apply(v[i].s); exp_q.push_back(v[i].e);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++; $display("FAIL branch cyc%0d got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
    total++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd1) begin
      bad++; $display("FAIL branch_cnt got=%0d/%0d want=0/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_pc_load();
    vec_t v[$];
    logic [7:0] e;
    do_reset();
    v.push_back({mk(1, 0, 0, 15, 1, 1, 1, 0), 8'b1010_00_00});
    v.push_back({mk(1, 15, 0, 5, 0, 0, 0, 0), 8'b1010_00_00});
    v.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b1010_00_00});
    v.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b0010_00_00});
    v.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b0000_00_00});
    foreach (v[i]) begin
      apply(v[i].s); exp_q.push_back(v[i].e);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++; $display("FAIL pc_load cyc%0d got=%b want=%b", i, obs, e);
      end
      @(posedge clk); #1;
    end
    total++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 32'd4) begin
      bad++; $display("FAIL pc_load_cnt got=%0d/%0d want=3/4", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_no_fwd();
    vec_t v[$];
    logic [7:0] e;
    do_reset();
    v.push_back({mk(1, 3, 4, 1, 1, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(1, 1, 5, 6, 1, 0, 0, 0), 8'b1101_00_00});
    v.push_back({mk(1, 1, 5, 6, 1, 0, 0, 0), 8'b1101_00_00});
    v.push_back({mk(1, 1, 5, 6, 1, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(1, 0, 0, 0, 0, 0, 1, 0), 8'b1010_00_00});
    v.push_back({mk(1, 0, 0, 0, 0, 0, 1, 0), 8'b1010_00_00});
    v.push_back({mk(1, 0, 0, 0, 0, 0, 1, 0), 8'b1010_00_00});
    foreach (v[i]) begin
      apply(v[i].s); exp_q.push_back(v[i].e);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs_nf !== e) begin
        bad++; $display("FAIL no_fwd cyc%0d got=%b want=%b", i, obs_nf, e);
      end
      @(posedge clk); #1;
    end
    total++;
    if (nf_stall_cnt !== 2'd3 || nf_flush_cnt !== 2'd3) begin
      bad++; $display("FAIL no_fwd_sat got=%0d/%0d want=3/3", nf_stall_cnt, nf_flush_cnt);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    logic [7:0] e;
    do_reset();
    v.push_back({mk(1, 3, 4, 2, 1, 1, 0, 0), 8'b0000_00_00});
    v.push_back({mk(1, 2, 6, 7, 1, 0, 0, 1), 8'b1111_00_00});
    v.push_back({mk(1, 2, 6, 7, 1, 0, 0, 0), 8'b0000_00_00});
    v.push_back({mk(1, 0, 0, 4, 1, 1, 0, 0), 8'b0000_10_00});
    v.push_back({mk(1, 4, 0, 9, 1, 0, 0, 0), 8'b1101_00_00});
    foreach (v[i]) begin
      apply(v[i].s); exp_q.push_back(v[i].e);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++; $display("FAIL b2b cyc%0d got=%b want=%b", i, obs, e);
      end
      if (i < v.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    // Reset lands on the edge ending the load-use stall cycle.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL mid_stall_reset got=%b want=%b", obs, 8'h00);
    end
    total++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      bad++; $display("FAIL mid_stall_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fwd_alu();
    test_youngest();
    test_load_use();
    test_branch();
    test_pc_load();
    test_no_fwd();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
